// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART <-> ALU framing stage.
// FSM encoding, default widths and the ALU opcode set.
package uart_alu_pkg;

    localparam int DBIT_DEF = 8;
    localparam int OP_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_LATCH   = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_NOR = 6'h27;

endpackage

// File: rtl/uart_alu_timeout.sv
// Inter-byte idle counter; only instantiated when UART_ALU_TIMEOUT_EN
// is defined. Saturates at CYCLES and flags expiry.
module uart_alu_timeout #(
    parameter int CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (i_inc && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/uart_alu_intf.sv
// Pops A, B, opcode from the RX FIFO, latches the ALU result, pushes it to TX.
// Optional inter-byte timeout: define UART_ALU_TIMEOUT_EN.
module uart_alu_intf
    import uart_alu_pkg::*;
#(
    parameter int DBIT           = DBIT_DEF,
    parameter int OP_W           = OP_W_DEF,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    input  logic [DBIT-1:0] alu_result,
    output logic [DBIT-1:0] a,
    output logic [DBIT-1:0] b,
    output logic [OP_W-1:0] op,
    output logic [DBIT-1:0] led
);

    state_t          r_state;
    state_t          w_state_next;
    logic            w_rd;
    logic            w_wr;
    logic            w_expired;
    logic [DBIT-1:0] r_a;
    logic [DBIT-1:0] r_b;
    logic [OP_W-1:0] r_op;
    logic [DBIT-1:0] r_res;
    logic [DBIT-1:0] r_led;

`ifdef UART_ALU_TIMEOUT_EN
    logic w_to_clr;
    logic w_to_inc;

    assign w_to_clr = w_rd || (r_state == ST_WAIT_A) ||
                      (r_state == ST_LATCH) || (r_state == ST_SEND);
    assign w_to_inc = rx_empty &&
                      ((r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP));

    uart_alu_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_to_clr),
        .i_inc     (w_to_inc),
        .o_expired (w_expired)
    );
`else
    // No timeout in this build: the FSM waits indefinitely between bytes.
    assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_WAIT_A;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_WAIT_A:
                if (!rx_empty) w_state_next = ST_WAIT_B;
            ST_WAIT_B:
                if (!rx_empty)     w_state_next = ST_WAIT_OP;
                else if (w_expired) w_state_next = ST_WAIT_A;
            ST_WAIT_OP:
                if (!rx_empty)     w_state_next = ST_LATCH;
                else if (w_expired) w_state_next = ST_WAIT_A;
            ST_LATCH:
                w_state_next = ST_SEND;
            ST_SEND:
                if (!tx_full) w_state_next = ST_WAIT_A;
            default:
                w_state_next = ST_WAIT_A;
        endcase
    end

    always_comb begin
        w_rd = 1'b0;
        w_wr = 1'b0;
        if (!reset) begin
            unique case (r_state)
                ST_WAIT_A, ST_WAIT_B, ST_WAIT_OP: w_rd = !rx_empty;
                ST_SEND:                          w_wr = !tx_full;
                default: ;
            endcase
        end
    end

    // Byte capture shares the pop edge; result latched in LATCH only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_res <= '0;
            r_led <= '0;
        end else begin
            if (w_rd && r_state == ST_WAIT_A)  r_a  <= r_data;
            if (w_rd && r_state == ST_WAIT_B)  r_b  <= r_data;
            if (w_rd && r_state == ST_WAIT_OP) r_op <= r_data[OP_W-1:0];
            if (r_state == ST_LATCH) begin
                r_res <= alu_result;
                r_led <= alu_result;
            end
        end
    end

    assign rd_uart = w_rd;
    assign wr_uart = w_wr;
    assign w_data  = r_res;
    assign a       = r_a;
    assign b       = r_b;
    assign op      = r_op;
    assign led     = r_led;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Scoreboard bench for uart_alu_intf: FIFO + ALU models, directed frames.
// Timeout scenario runs only when UART_ALU_TIMEOUT_EN is defined.
module tb_uart_alu_intf;
    import uart_alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       tx_full = 1'b0;
    logic       rd_uart, wr_uart;
    logic [7:0] w_data, alu_result, a, b, led;
    logic [5:0] op;

    logic [7:0] rxq[$];
    logic [7:0] sb[$];
    int nvec = 0;
    int nerr = 0;
    int nwr = 0;

    uart_alu_intf #(
        .DBIT(8), .OP_W(6), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart),
        .w_data(w_data), .alu_result(alu_result), .a(a), .b(b), .op(op),
        .led(led)
    );

    always #10 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic [5:0] o);
        logic [2:0] sh;
        sh = y[2:0];
        case (o)
            OP_ADD: return x + y;
            OP_SUB: return x - y;
            OP_AND: return x & y;
            OP_OR:  return x | y;
            OP_XOR: return x ^ y;
            OP_NOR: return ~(x | y);
            OP_SRL: return x >> sh;
            OP_SRA: return 8'($signed(x) >>> sh);
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_f(a, b, op);

    function automatic void upd();
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    endfunction

    // RX FIFO pop, applied just after the edge that consumed the head
    logic [7:0] popped;
    always @(posedge clk) begin
        if (rd_uart) begin
            #1;
            if (rxq.size() > 0) popped = rxq.pop_front();
            upd();
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every TX push is matched against the scoreboard
    logic [7:0] mexp;
    always @(negedge clk) begin
        if (wr_uart) begin
            nwr++;
            chk("wr while tx_full", tx_full, 0);
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected wr_uart: got %0h expected none",
                         w_data);
            end else begin
                mexp = sb.pop_front();
                chk("w_data", w_data, mexp);
                chk("led at wr", led, mexp);
            end
        end
    end

    task automatic push1(input logic [7:0] v);
        rxq.push_back(v);
        upd();
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] o, input logic [7:0] res);
        sb.push_back(res);
        rxq.push_back(x);
        rxq.push_back(y);
        rxq.push_back(o);
        upd();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0;
        logic [11:0] pat;
        int n;

        @(negedge clk);
        push1(8'h01);
        sb.push_back(8'h04);
        repeat (2) @(negedge clk);
        chk("reset a", a, 0);
        chk("reset b", b, 0);
        chk("reset op", op, 0);
        chk("reset led", led, 0);
        chk("reset w_data", w_data, 0);
        chk("reset rd_uart", rd_uart, 0);
        chk("reset wr_uart", wr_uart, 0);
        chk("reset no pop", rxq.size(), 1);
        reset = 1'b0;

        // frame 1: 01 + 03 = 04, A already queued during reset
        @(negedge clk);
        push1(8'h03);
        push1(8'h20);
        drain("frame1 drain");
        chk("frame1 a", a, 8'h01);
        chk("frame1 b", b, 8'h03);
        chk("frame1 op", op, 6'h20);
        chk("frame1 led", led, 8'h04);

        // spaced bytes, AND; check 2-cycle latency from opcode pop
        push1(8'h0F);
        repeat (3) @(negedge clk);
        push1(8'h33);
        repeat (3) @(negedge clk);
        sb.push_back(8'h03);
        push1(8'h24);
        @(negedge clk);
        chk("latch cycle no wr", wr_uart, 0);
        chk("latch cycle led old", led, 8'h04);
        @(negedge clk);
        chk("send cycle wr", wr_uart, 1);
        chk("send cycle led new", led, 8'h03);
        drain("and drain");

        // TX back-pressure: OR 10|20 = 30
        tx_full = 1'b1;
        w0 = nwr;
        send(8'h10, 8'h20, 8'h25, 8'h30);
        repeat (15) @(negedge clk);
        chk("held no wr", nwr, w0);
        chk("held wr_uart", wr_uart, 0);
        tx_full = 1'b0;
        drain("backpressure drain");
        chk("one pulse", nwr, w0 + 1);

        // two frames preloaded: XOR AA^55=FF, SRA 81>>>1=C0
        send(8'hAA, 8'h55, 8'h26, 8'hFF);
        send(8'h81, 8'h01, 8'h03, 8'hC0);
        #1;
        for (int i = 0; i < 12; i++) begin
            pat[i] = rd_uart;
            @(negedge clk);
            #1;
        end
        chk("rd_uart pattern", pat, 12'h0E7);
        drain("two frame drain");

        // reset after A popped: stale A discarded, SUB 05-02=03
        push1(8'h09);
        n = 0;
        while (a != 8'h09 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("partial a", a, 8'h09);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset a", a, 0);
        send(8'h05, 8'h02, 8'h22, 8'h03);
        drain("sub drain");
        chk("sub a", a, 8'h05);

        // opcode upper bits ignored: E0 -> ADD
        send(8'h07, 8'h08, 8'hE0, 8'h0F);
        drain("e0 drain");
        chk("e0 op", op, 6'h20);

        // SUB wrap, NOR, SRL
        send(8'h02, 8'h05, 8'h22, 8'hFD);
        send(8'hF0, 8'h0C, 8'h27, 8'h03);
        send(8'h80, 8'h03, 8'h02, 8'h10);
        drain("misc drain");

`ifdef UART_ALU_TIMEOUT_EN
        w0 = nwr;
        push1(8'h11);
        repeat (110) @(negedge clk);
        chk("timeout no wr", nwr, w0);
        send(8'h01, 8'h02, 8'h20, 8'h03);
        drain("timeout drain");
        chk("timeout fresh a", a, 8'h01);
        chk("timeout fresh b", b, 8'h02);
`endif

        chk("scoreboard empty", sb.size(), 0);
        chk("rx fifo empty", rxq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
